// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, branch conditions,
// forwarding selects and multiplier FSM states.
package exec_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_PSB = 4'd9;
  localparam logic [3:0] ALU_SLT = 4'd10;
  localparam logic [3:0] ALU_MUL = 4'd12;

  localparam logic [2:0] BR_EQ = 3'd0;
  localparam logic [2:0] BR_NE = 3'd1;
  localparam logic [2:0] BR_LT = 3'd2;
  localparam logic [2:0] BR_GE = 3'd3;
  localparam logic [2:0] BR_GT = 3'd4;
  localparam logic [2:0] BR_LE = 3'd5;
  localparam logic [2:0] BR_AL = 3'd6;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles.
// done is high during the cycle whose edge performs the final iteration.
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kill,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] a_q, b_q;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  assign done = running & (cnt == LAST);

  // NOTE: operand latches carry no reset; they are only read while running,
  // which is itself reset, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (start) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
    end else if (kill) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
    end else if (running) begin
      if (b_q[cnt]) acc <= acc + (a_q << cnt);
      cnt <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_pipe_stage.sv
// Registered execute stage: operand select, ALU, branch resolve, EX/MEM register.
// Define EXEC_MUL_EN to enable the iterative multiplier and its Busy FSM.
module exec_pipe_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int IMMA_W = 6,
  parameter int IMMB_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  output logic              Busy,
  input  logic              KillIn,
  input  logic [PC_W-1:0]   PCIn,
  input  logic [DATA_W-1:0] RqRd,
  input  logic [DATA_W-1:0] Rs,
  input  logic [15:0]       instr,
  input  logic              JumpHigh,
  input  logic              BranchHigh,
  input  logic              RqRdOrImm,
  input  logic              RsOrImm,
  input  logic [3:0]        ALUCtrl,
  input  logic [1:0]        FwdA,
  input  logic [1:0]        FwdB,
  input  logic [DATA_W-1:0] MemData,
  input  logic [DATA_W-1:0] WbData,
  output logic              OutValid,
  output logic [DATA_W-1:0] ALUOut,
  output logic [PC_W-1:0]   PCOut,
  output logic              SelectJOrB,
  output logic              flush
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic [SH_W-1:0]   shamt;
  logic              cond, taken, is_mul, issue_alu;
  logic [PC_W-1:0]   next_pc;
  logic              unused_instr;

  assign unused_instr = ^instr[15:11];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fwd_a = RqRd;
    fwd_b = Rs;
    if (FwdA == FWD_MEM) fwd_a = MemData;
    else if (FwdA == FWD_WB) fwd_a = WbData;
    if (FwdB == FWD_MEM) fwd_b = MemData;
    else if (FwdB == FWD_WB) fwd_b = WbData;
  end

  assign op_a  = RqRdOrImm ? {{(DATA_W-IMMA_W){1'b0}}, instr[IMMA_W-1:0]} : fwd_a;
  assign op_b  = RsOrImm   ? {{(DATA_W-IMMB_W){1'b0}}, instr[IMMB_W-1:0]} : fwd_b;
  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOT: alu_res = ~op_a;
      ALU_SLL: alu_res = op_a << shamt;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $signed(op_a) >>> shamt;
      ALU_PSB: alu_res = op_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // Condition codes test operand B as a signed value against zero.
  always_comb begin
    cond = 1'b1;
    case (instr[10:8])
      BR_EQ:   cond = (op_b == '0);
      BR_NE:   cond = (op_b != '0);
      BR_LT:   cond = op_b[DATA_W-1];
      BR_GE:   cond = !op_b[DATA_W-1];
      BR_GT:   cond = !op_b[DATA_W-1] && (op_b != '0);
      BR_LE:   cond = op_b[DATA_W-1] || (op_b == '0);
      default: cond = 1'b1;
    endcase
  end

  assign is_mul  = (ALUCtrl == ALU_MUL);
  assign taken   = InValid & !is_mul & (JumpHigh | (BranchHigh & cond));
  assign next_pc = taken ? fwd_a[PC_W-1:0] : PCIn;

`ifdef EXEC_MUL_EN
  state_t            state;
  logic              accept, mul_start, mul_done, mul_out;
  logic [DATA_W-1:0] mul_acc;
  logic [PC_W-1:0]   mul_pc;

  // DONE owns the EX/MEM register on its edge, so only a MUL may issue behind
  // it; a waiting non-MUL is held off by Busy for that one cycle.
  assign Busy      = (state == S_MUL) | ((state == S_DONE) & InValid & !is_mul);
  assign accept    = InValid & !Busy;
  assign mul_start = accept & is_mul & !KillIn;
  assign issue_alu = accept & !is_mul & !KillIn;
  assign mul_out   = (state == S_DONE) & !KillIn;

  exec_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .kill  (KillIn),
    .a     (op_a),
    .b     (op_b),
    .acc   (mul_acc),
    .done  (mul_done)
  );

  always_ff @(posedge clk) begin
    if (mul_start) mul_pc <= PCIn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      state <= S_IDLE;
    else if (KillIn) state <= S_IDLE;
    else begin
      case (state)
        S_MUL:   if (mul_done) state <= S_DONE;
        default: state <= mul_start ? S_MUL : S_IDLE;
      endcase
    end
  end
`else
  assign Busy      = 1'b0;
  assign issue_alu = InValid & !KillIn;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      OutValid   <= 1'b0;
      ALUOut     <= '0;
      PCOut      <= '0;
      SelectJOrB <= 1'b0;
      flush      <= 1'b0;
    end else begin
      OutValid   <= 1'b0;
      SelectJOrB <= 1'b0;
      flush      <= 1'b0;
      if (issue_alu) begin
        OutValid   <= 1'b1;
        ALUOut     <= alu_res;
        PCOut      <= next_pc;
        SelectJOrB <= taken;
        flush      <= taken;
      end
`ifdef EXEC_MUL_EN
      if (mul_out) begin
        OutValid <= 1'b1;
        ALUOut   <= mul_acc;
        PCOut    <= mul_pc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_pipe_stage.sv
// Self-checking bench for exec_pipe_stage; expected EX/MEM contents are queued
// at issue and compared when OutValid appears. Honours EXEC_MUL_EN.
module tb_exec_pipe_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [15:0] pc;
    logic        sel;
  } exp_t;

  logic        clk, rst_n, InValid, KillIn, Busy;
  logic [15:0] PCIn, instr, PCOut;
  logic [31:0] RqRd, Rs, MemData, WbData, ALUOut;
  logic        JumpHigh, BranchHigh, RqRdOrImm, RsOrImm;
  logic [3:0]  ALUCtrl;
  logic [1:0]  FwdA, FwdB;
  logic        OutValid, SelectJOrB, flush;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_seen = 0;

  exec_pipe_stage dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .Busy(Busy), .KillIn(KillIn),
    .PCIn(PCIn), .RqRd(RqRd), .Rs(Rs), .instr(instr),
    .JumpHigh(JumpHigh), .BranchHigh(BranchHigh), .RqRdOrImm(RqRdOrImm), .RsOrImm(RsOrImm),
    .ALUCtrl(ALUCtrl), .FwdA(FwdA), .FwdB(FwdB), .MemData(MemData), .WbData(WbData),
    .OutValid(OutValid), .ALUOut(ALUOut), .PCOut(PCOut), .SelectJOrB(SelectJOrB), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r, m, w);
    if (s == 2'd1) return m;
    if (s == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd9:  return b;
      4'd10: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
`ifdef EXEC_MUL_EN
      4'd12: return a * b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_cond(input logic [2:0] c, input logic [31:0] b);
    int v;
    v = $signed(b);
    case (c)
      3'd0: return v == 0;
      3'd1: return v != 0;
      3'd2: return v < 0;
      3'd3: return v >= 0;
      3'd4: return v > 0;
      3'd5: return v <= 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_idle();
    InValid = 0; KillIn = 0; PCIn = 16'h0100; RqRd = 0; Rs = 0; instr = 0;
    JumpHigh = 0; BranchHigh = 0; RqRdOrImm = 0; RsOrImm = 0; ALUCtrl = 0;
    FwdA = 0; FwdB = 0; MemData = 0; WbData = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the current inputs for one edge; optionally queue the expectation.
  task automatic issue(input bit push);
    exp_t e;
    logic [31:0] fa, fb, oa, ob;
    logic tk;
    fa = fwd(FwdA, RqRd, MemData, WbData);
    fb = fwd(FwdB, Rs, MemData, WbData);
    oa = RqRdOrImm ? {26'd0, instr[5:0]} : fa;
    ob = RsOrImm ? {24'd0, instr[7:0]} : fb;
    tk = (ALUCtrl != 4'd12) && (JumpHigh || (BranchHigh && m_cond(instr[10:8], ob)));
    e.alu = m_alu(ALUCtrl, oa, ob);
    e.pc  = tk ? fa[15:0] : PCIn;
    e.sel = tk;
    if (push) sb.push_back(e);
    InValid = 1;
    tick();
    InValid = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ov"},   64'(OutValid),   64'd0);
    check({tag, "_alu"},  64'(ALUOut),     64'd0);
    check({tag, "_pc"},   64'(PCOut),      64'd0);
    check({tag, "_sel"},  64'(SelectJOrB), 64'd0);
    check({tag, "_fl"},   64'(flush),      64'd0);
    check({tag, "_busy"}, 64'(Busy),       64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (OutValid) begin
        if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else begin
          mon_e = sb.pop_front();
          check("sb_alu",   64'(ALUOut),     64'(mon_e.alu));
          check("sb_pc",    64'(PCOut),      64'(mon_e.pc));
          check("sb_sel",   64'(SelectJOrB), 64'(mon_e.sel));
          check("sb_flush", 64'(flush),      64'(mon_e.sel));
        end
      end
      if (Busy) busy_seen++;
    end
  end

  initial begin
    int ov_cnt, busy_cnt, edges, ov_edges;
    set_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1;

`ifdef EXEC_MUL_EN
    // Reset in the middle of a multiply aborts it silently.
    ALUCtrl = 4'd12; RqRd = 32'd7; Rs = 32'd9;
    issue(0);
    repeat (4) tick();
    check("mulrst_busy_pre", 64'(Busy), 64'd1);
    set_idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    check_reset_state("mulrst");
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (OutValid) ov_cnt++;
    end
    check("mulrst_no_ov", 64'(ov_cnt), 64'd0);
`endif

    // ADD 3+4, one-edge latency.
    set_idle();
    RqRd = 32'd3; Rs = 32'd4;
    issue(1);
    check("add_valid", 64'(OutValid), 64'd1);
    check("add_res",   64'(ALUOut),   64'd7);

    // Forwarded A from MEM, then immediate B.
    set_idle();
    FwdA = 2'd1; MemData = 32'h10; RqRd = 32'hDEAD; Rs = 32'h5;
    issue(1);
    check("fwd_add", 64'(ALUOut), 64'h15);
    set_idle();
    ALUCtrl = 4'd9; RsOrImm = 1; instr = 16'h00FF; Rs = 32'h1234_5678;
    issue(1);
    check("immb_pass", 64'(ALUOut), 64'hFF);

    // Taken LT branch, single flush pulse.
    set_idle();
    BranchHigh = 1; instr = 16'h0200; Rs = 32'hFFFF_FFFF; RqRd = 32'h0040; PCIn = 16'h0222;
    issue(1);
    check("br_sel",   64'(SelectJOrB), 64'd1);
    check("br_pc",    64'(PCOut),      64'h40);
    check("br_flush", 64'(flush),      64'd1);
    BranchHigh = 0;
    tick();
    check("br_flush_once", 64'(flush), 64'd0);
    set_idle();
    BranchHigh = 1; instr = 16'h0200; Rs = 32'd1; RqRd = 32'h0040; PCIn = 16'h0222;
    issue(1);
    check("nbr_pc",    64'(PCOut), 64'h0222);
    check("nbr_flush", 64'(flush), 64'd0);

    // Mixed random traffic, back to back, checked through the scoreboard.
    for (int i = 0; i < 24; i++) begin
      int unsigned op;
      op = $urandom_range(0, 15);
      if (op == 12) op = 0;
      ALUCtrl = 4'(op);
      RqRd = $urandom; Rs = $urandom; MemData = $urandom; WbData = $urandom;
      if (i % 3 == 0) Rs = (i % 2 == 0) ? 32'd0 : 32'h8000_0000;
      FwdA = 2'($urandom_range(0, 3)); FwdB = 2'($urandom_range(0, 3));
      RqRdOrImm = 1'($urandom_range(0, 1)); RsOrImm = 1'($urandom_range(0, 1));
      instr = 16'($urandom); PCIn = 16'($urandom);
      JumpHigh = ($urandom_range(0, 3) == 0); BranchHigh = 1'($urandom_range(0, 1));
      issue(1);
    end
    set_idle();
    tick();

    // Kill beats a taken jump.
    JumpHigh = 1; RqRd = 32'h80; KillIn = 1;
    issue(0);
    check("kill_jmp_flush", 64'(flush),    64'd0);
    check("kill_jmp_ov",    64'(OutValid), 64'd0);
    set_idle();

`ifdef EXEC_MUL_EN
    // Kill also drops a MUL offered in the same cycle.
    ALUCtrl = 4'd12; RqRd = 32'd2; Rs = 32'd2; KillIn = 1;
    issue(0);
    check("kill_mul_busy", 64'(Busy), 64'd0);
    set_idle();

    // Multiply with an ADD offered mid-flight that must be ignored.
    ALUCtrl = 4'd12; RqRd = 32'h1234; Rs = 32'h10; PCIn = 16'h0300;
    issue(1);
    busy_cnt = 0; ov_cnt = 0; edges = 1; ov_edges = 0;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busy_cnt++;
      if (OutValid) begin
        ov_cnt++;
        if (ov_edges == 0) ov_edges = edges;
      end
      if (i == 3) begin ALUCtrl = 4'd0; RqRd = 32'd1; Rs = 32'd1; InValid = 1; end
      if (i == 6) InValid = 0;
      tick();
      edges++;
    end
    check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
    check("mul_latency",     64'(ov_edges), 64'd34);
    check("mul_ov_once",     64'(ov_cnt),   64'd1);
    set_idle();

    // Kill at multiply cycle 10 discards the result.
    ALUCtrl = 4'd12; RqRd = 32'd5; Rs = 32'd6;
    issue(0);
    set_idle();
    repeat (9) tick();
    KillIn = 1;
    tick();
    KillIn = 0;
    check("kill_mul_idle", 64'(Busy), 64'd0);
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (OutValid) ov_cnt++;
    end
    check("kill_mul_no_ov", 64'(ov_cnt), 64'd0);
`else
    // Without the multiplier MUL is a single-cycle op yielding zero.
    ALUCtrl = 4'd12; RqRd = 32'd3; Rs = 32'd5;
    issue(1);
    check("mul_off_valid", 64'(OutValid), 64'd1);
    check("mul_off_res",   64'(ALUOut),   64'd0);
    check("mul_off_busy",  64'(Busy),     64'd0);
`endif

    set_idle();
    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
`ifdef EXEC_MUL_EN
    check("busy_seen", 64'(busy_seen != 0), 64'd1);
`else
    check("busy_never", 64'(busy_seen), 64'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_pipe_stage.md
Name: exec_pipe_stage

Overview:
- Parametrised, registered successor to the combinational execute stage.
- Selects operands with an optional immediate and MEM/WB forwarding, then computes the ALU result.
- Resolves jumps and branches and drives the EX/MEM pipeline register.
- Adds an iterative shift-add multiplier that stalls upstream while busy; the block sits between ID/EX and MEM.

Parameters:
- DATA_W, 32, datapath width of operands and result.
- PC_W, 16, program counter width.
- IMMA_W, 6, width of A-immediate, instr[IMMA_W-1:0], zero-extended.
- IMMB_W, 8, width of B-immediate, instr[IMMB_W-1:0], zero-extended.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- InValid  in  1  ID/EX holds a valid instruction.
- Busy  out  1  multiplier running; upstream must hold its inputs.
- KillIn  in  1  squash the in-flight or accepted instruction.
- PCIn  in  PC_W  sequential next PC.
- RqRd  in  DATA_W  register read data A.
- Rs  in  DATA_W  register read data B.
- instr  in  16  instruction word.
- JumpHigh, BranchHigh, RqRdOrImm, RsOrImm  in  1 each  control signals.
- ALUCtrl  in  4  operation code.
- FwdA, FwdB  in  2 each  operand source: 0 = register, 1 = MemData, 2 = WbData, 3 = register.
- MemData, WbData  in  DATA_W  forwarded values.
- OutValid  out  1  EX/MEM register valid.
- ALUOut  out  DATA_W  registered result.
- PCOut  out  PC_W  registered next PC.
- SelectJOrB  out  1  registered: control transfer taken.
- flush  out  1  one-cycle pulse: squash IF/ID.

Behaviour:
- Reset (rst_n=0 at posedge): OutValid, ALUOut, PCOut, SelectJOrB, flush and Busy all go to 0; FSM returns to IDLE. Reset mid-multiply aborts it with no output.
- Operand A: forwarded RqRd, or zero-extended instr[IMMA_W-1:0] when RqRdOrImm=1. Operand B is formed the same way from Rs, RsOrImm and IMMB_W. Forwarding applies before the immediate mux.
- ALU ops (ALUCtrl): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL, 7 SRL, 8 SRA, 9 PASS B, 10 SLT signed, C MUL (low DATA_W bits); others give 0.
- Shift amount is B[$clog2(DATA_W)-1:0].
- Arithmetic wraps modulo 2^DATA_W.
- Condition codes compare operand B, signed, against zero.
- Branch condition is instr[10:8]: 0 EQ, 1 NE, 2 LT, 3 GE, 4 GT, 5 LE, 6-7 always.
- Taken = InValid & (JumpHigh | (BranchHigh & cond)). A branch whose condition fails is not taken.
- PCOut = taken ? forwarded RqRd[PC_W-1:0] : PCIn.
- FSM IDLE, non-MUL: an accepted instruction (InValid & !Busy) registers ALUOut, PCOut, SelectJOrB and flush=taken with OutValid=1 at the next edge. Latency is 1.
- InValid=0 gives OutValid=0 and flush=0; ALUOut holds its last value.
- FSM IDLE, MUL accepted: latch A and B, counter=0, go to MUL. Busy=1 combinationally while in MUL. OutValid=0 during MUL.
- FSM MUL: each cycle, if B[cnt] then acc += A<<cnt; cnt++. After DATA_W iterations go to DONE.
- FSM DONE: ALUOut=acc, OutValid=1, Busy=0, return to IDLE.
  - Total latency is DATA_W+2 edges from acceptance.
  - Back-to-back issue is allowed in the same DONE cycle.
- MUL never branches; SelectJOrB=0.
- InValid while Busy is ignored.
- KillIn=1 has priority over everything except reset:
  - At the edge it forces OutValid=0 and flush=0.
  - In MUL or DONE it returns the FSM to IDLE and discards the result.
- A simultaneous InValid is dropped.
- flush is exactly one cycle per taken transfer, never two in a row for one instruction.

Optional Feature:
- EXEC_MUL_EN defined: iterative multiplier and Busy FSM as above.
- Undefined: ALUCtrl=C is a 1-cycle op producing 0, Busy is tied to 0 and the FSM is IDLE-only.

Decomposition:
- Package exec_pkg holds:
  - ALU opcode localparams (ALU_ADD..ALU_MUL);
  - branch condition codes (BR_EQ..BR_AL);
  - forwarding select encodings (FWD_REG, FWD_MEM, FWD_WB);
  - FSM state enum (S_IDLE, S_MUL, S_DONE).
- One sub-module, exec_mul_iter, holds the counter, accumulator and done pulse, parametrised by DATA_W.
- ALU and branch compare stay inline.

Test Plan:
- Reset held 2 cycles mid-MUL (cycle 5 of 32), then released: all outputs 0, Busy=0, next ADD 3+4 -> ALUOut=7 one cycle later.
- ADD with FwdA=1, MemData=0x10, Rs=0x5 -> ALUOut=0x15, OutValid=1 one edge later; RsOrImm=1 with instr[7:0]=0xFF -> operand B=0x000000FF.
- BranchHigh, instr[10:8]=2 (LT), Rs=0xFFFFFFFF, RqRd=0x0040 -> SelectJOrB=1, PCOut=0x0040, single flush pulse; the same instruction with Rs=1 -> PCOut=PCIn, flush=0.
- MUL A=0x1234, B=0x10 (EXEC_MUL_EN) -> Busy=1 for 32 cycles, ALUOut=0x12340, OutValid high for exactly 1 cycle after 34 edges; an InValid ADD during Busy is ignored.
- KillIn asserted at MUL cycle 10 -> FSM back to IDLE, no OutValid pulse; KillIn with a taken JumpHigh -> flush=0.
- Without EXEC_MUL_EN: MUL A=3, B=5 -> ALUOut=0 in 1 cycle, Busy never asserts.
